// File: rtl/sel_mux8_pipe.sv
// sel_mux8_pipe: two-stage valid/ready ALU/mux pipeline.
// Stage 1 registers the operand set, stage 2 computes and registers y.
// Optional {carry, neg, zero} flags output enabled by SEL_MUX8_PIPE_FLAGS_EN.
module sel_mux8_pipe #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic [2:0]   op,
   input  logic         in_valid,
   output logic         in_ready,
   output logic [N-1:0] y,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [15:0]  cnt
`ifdef SEL_MUX8_PIPE_FLAGS_EN
   ,
   output logic [2:0]   flags
`endif
);

   logic         s1_valid, s2_valid;
   logic [N-1:0] s1_a, s1_b;
   logic [2:0]   s1_op;
   logic [N-1:0] res;
   logic         accept, deliver, s1_move;

   // Handshakes; reset gating keeps both sides quiet while rst_n is low.
   assign in_ready  = rst_n & (!s1_valid | !s2_valid | out_ready);
   assign out_valid = rst_n & s2_valid;
   assign accept    = in_valid & in_ready;
   assign deliver   = out_valid & out_ready;
   // Stage 1 advances when stage 2 is empty or being drained this edge.
   assign s1_move   = s1_valid & (!s2_valid | out_ready);

   // Stage 2 combinational result from the registered operand set.
   always_comb begin
      res = '0;
      case (s1_op)
         3'b000:  res = s1_a & s1_b;
         3'b001:  res = s1_a | s1_b;
         3'b010:  res = s1_a ^ s1_b;
         3'b011:  res = ~(s1_a & s1_b);
         3'b100:  res = s1_a + s1_b;
         3'b101:  res = s1_a - s1_b;
         3'b110:  res = s1_a;
         default: res = s1_b;
      endcase
   end

   // Stage 1 register: load on accept, empty when moved on without refill.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_a     <= '0;
         s1_b     <= '0;
         s1_op    <= '0;
      end else if (accept) begin
         s1_valid <= 1'b1;
         s1_a     <= a;
         s1_b     <= b;
         s1_op    <= op;
      end else if (s1_move) begin
         s1_valid <= 1'b0;
      end
   end

   // Stage 2 register: y only changes when a new result moves in.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s2_valid <= 1'b0;
         y        <= '0;
      end else if (s1_move) begin
         s2_valid <= 1'b1;
         y        <= res;
      end else if (deliver) begin
         s2_valid <= 1'b0;
      end
   end

   // Delivery counter, free-running wrap at 16 bits.
   always_ff @(posedge clk) begin
      if (!rst_n)       cnt <= '0;
      else if (deliver) cnt <= cnt + 16'd1;
   end

`ifdef SEL_MUX8_PIPE_FLAGS_EN
   logic carry;

   // Carry-out of a+b happens exactly when a > ~b; borrow of a-b when a < b.
   always_comb begin
      carry = 1'b0;
      if (s1_op == 3'b100)      carry = (s1_a > ~s1_b);
      else if (s1_op == 3'b101) carry = (s1_a < s1_b);
   end

   // Flags register tracks y.
   always_ff @(posedge clk) begin
      if (!rst_n)       flags <= '0;
      else if (s1_move) flags <= {carry, res[N-1], (res == '0)};
   end
`endif

endmodule

// File: tb/tb_sel_mux8_pipe.sv
// tb_sel_mux8_pipe: randomized self-checking bench for sel_mux8_pipe.
// Main DUT at N=8, a second instance at N=9 for the op-table scenario.
module tb_sel_mux8_pipe;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [7:0]  a = '0, b = '0, y;
   logic [2:0]  op = '0;
   logic        in_valid = 1'b0, out_ready = 1'b0, in_ready, out_valid;
   logic [15:0] cnt;
   logic [8:0]  a9 = '0, b9 = '0, y9;
   logic [2:0]  op9 = '0;
   logic        iv9 = 1'b0, or9 = 1'b0, ir9, ov9;
   logic [15:0] cnt9;
`ifdef SEL_MUX8_PIPE_FLAGS_EN
   logic [2:0]  flags, flags9;
`endif

   sel_mux8_pipe #(.N(8)) dut (
      .clk(clk), .rst_n(rst_n), .a(a), .b(b), .op(op), .in_valid(in_valid),
      .in_ready(in_ready), .y(y), .out_valid(out_valid), .out_ready(out_ready), .cnt(cnt)
`ifdef SEL_MUX8_PIPE_FLAGS_EN
      , .flags(flags)
`endif
   );

   sel_mux8_pipe #(.N(9)) dut9 (
      .clk(clk), .rst_n(rst_n), .a(a9), .b(b9), .op(op9), .in_valid(iv9),
      .in_ready(ir9), .y(y9), .out_valid(ov9), .out_ready(or9), .cnt(cnt9)
`ifdef SEL_MUX8_PIPE_FLAGS_EN
      , .flags(flags9)
`endif
   );

   int checks = 0;
   int failures = 0;

   // Expected result as {flags, y} straight from the operation table.
   function automatic logic [10:0] ref_res(input logic [7:0] av, input logic [7:0] bv,
                                           input logic [2:0] opv);
      int ai, bi, r;
      logic c;
      ai = int'(av);
      bi = int'(bv);
      c  = 1'b0;
      case (opv)
         3'd0: r = ai & bi;
         3'd1: r = ai | bi;
         3'd2: r = ai ^ bi;
         3'd3: r = 255 - (ai & bi);
         3'd4: begin r = ai + bi; c = (r > 255); end
         3'd5: begin r = ai - bi; c = (r < 0); end
         3'd6: r = ai;
         default: r = bi;
      endcase
      r = r & 255;
      return {c, (r >= 128), (r == 0), 8'(r)};
   endfunction

   function automatic logic [2:0] cur_flags();
`ifdef SEL_MUX8_PIPE_FLAGS_EN
      return flags;
`else
      return 3'b000;
`endif
   endfunction

   // One clock of the N=8 DUT: sample handshakes and outputs, then advance.
   task automatic step(output bit acc, output bit dlv, output logic [7:0] yv,
                       output logic [2:0] fv);
      #1;
      acc = in_valid && in_ready;
      dlv = out_valid && out_ready;
      yv  = y;
      fv  = cur_flags();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) begin @(posedge clk); @(negedge clk); end
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
         failures++; $display("FAIL reset_hs out_valid=%b in_ready=%b want 0 0", out_valid, in_ready);
      end
      checks++;
      if (y !== 8'h00 || cnt !== 16'h0) begin
         failures++; $display("FAIL reset_regs y=%h cnt=%h want 00 0000", y, cnt);
      end
      checks++;
      if (ov9 !== 1'b0 || y9 !== 9'h000 || cnt9 !== 16'h0) begin
         failures++; $display("FAIL reset_n9 ov=%b y=%h cnt=%h want 0 000 0000", ov9, y9, cnt9);
      end
      rst_n = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         failures++; $display("FAIL reset_release in_ready=%b want 1", in_ready);
      end
   endtask

   task automatic test_ops_n9();
      logic [8:0] exp9 [8];
      exp9 = '{9'h006, 9'h00F, 9'h009, 9'h1F9, 9'h015, 9'h009, 9'h00F, 9'h006};
      a9 = 9'h00F; b9 = 9'h006; or9 = 1'b1;
      for (int t = 0; t < 12; t++) begin
         op9 = 3'(t);
         iv9 = (t < 8);
         #1;
         if (t < 8) begin
            checks++;
            if (ir9 !== 1'b1) begin
               failures++; $display("FAIL ops_accept t=%0d in_ready=%b want 1", t, ir9);
            end
         end
         checks++;
         if (ov9 !== (t >= 2 && t < 10)) begin
            failures++; $display("FAIL ops_latency t=%0d out_valid=%b want %b", t, ov9, (t >= 2 && t < 10));
         end else if (t >= 2 && t < 10) begin
            checks++;
            if (y9 !== exp9[t-2]) begin
               failures++; $display("FAIL ops_y op=%0d y=%h want %h", t - 2, y9, exp9[t-2]);
            end
         end
         @(posedge clk);
         @(negedge clk);
      end
      iv9 = 1'b0;
      checks++;
      if (cnt9 !== 16'd8) begin
         failures++; $display("FAIL ops_cnt cnt=%0d want 8", cnt9);
      end
   endtask

   task automatic test_wrap();
      bit acc, dlv;
      logic [7:0] yv;
      logic [2:0] fv;
      int got;
      logic [7:0] ey [2];
      logic [2:0] ef [2];
      ey = '{8'h00, 8'hFF};
      ef = '{3'b101, 3'b110};
      out_ready = 1'b1;
      in_valid = 1'b1; a = 8'hFF; b = 8'h01; op = 3'b100;
      step(acc, dlv, yv, fv);
      a = 8'h00; b = 8'h01; op = 3'b101;
      step(acc, dlv, yv, fv);
      in_valid = 1'b0;
      got = 0;
      for (int i = 0; i < 6; i++) begin
         step(acc, dlv, yv, fv);
         if (dlv && got < 2) begin
            checks++;
            if (yv !== ey[got]) begin
               failures++; $display("FAIL wrap_y idx=%0d y=%h want %h", got, yv, ey[got]);
            end
`ifdef SEL_MUX8_PIPE_FLAGS_EN
            checks++;
            if (fv !== ef[got]) begin
               failures++; $display("FAIL wrap_flags idx=%0d flags=%b want %b", got, fv, ef[got]);
            end
`endif
            got++;
         end
      end
      checks++;
      if (got != 2) begin
         failures++; $display("FAIL wrap_count got=%0d want 2", got);
      end
   endtask

   task automatic test_backpressure();
      bit acc, dlv;
      logic [7:0] yv;
      logic [2:0] fv;
      int nacc;
      logic [10:0] exp [2];
      nacc = 0;
      out_ready = 1'b0;
      in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         a = 8'($urandom); b = 8'($urandom); op = 3'($urandom);
         step(acc, dlv, yv, fv);
         if (acc) begin
            if (nacc < 2) exp[nacc] = ref_res(a, b, op);
            nacc++;
         end
         if (i == 3) begin
            checks++;
            if (yv !== exp[0][7:0]) begin
               failures++; $display("FAIL bp_stall_y y=%h want %h", yv, exp[0][7:0]);
            end
         end
      end
      checks++;
      if (nacc != 2) begin
         failures++; $display("FAIL bp_accepts got=%0d want 2", nacc);
      end
      #1;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || y !== exp[0][7:0]) begin
         failures++; $display("FAIL bp_full in_ready=%b out_valid=%b y=%h want 0 1 %h",
                              in_ready, out_valid, y, exp[0][7:0]);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         step(acc, dlv, yv, fv);
         checks++;
         if (!dlv || yv !== exp[i][7:0]) begin
            failures++; $display("FAIL bp_drain idx=%0d dlv=%b y=%h want 1 %h", i, dlv, yv, exp[i][7:0]);
         end
      end
      step(acc, dlv, yv, fv);
      checks++;
      if (dlv) begin
         failures++; $display("FAIL bp_empty dlv=%b want 0", dlv);
      end
   endtask

   task automatic test_reset_midflight();
      bit acc, dlv;
      logic [7:0] yv;
      logic [2:0] fv;
      int nacc, ndlv;
      nacc = 0; ndlv = 0;
      out_ready = 1'b0;
      in_valid = 1'b1;
      for (int i = 0; i < 2; i++) begin
         a = 8'($urandom) | 8'h01; b = 8'($urandom); op = 3'b110;
         step(acc, dlv, yv, fv);
         if (acc) nacc++;
      end
      in_valid = 1'b0;
      checks++;
      if (nacc != 2) begin
         failures++; $display("FAIL mid_accepts got=%0d want 2", nacc);
      end
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0 || y !== 8'h00 || cnt !== 16'h0 || in_ready !== 1'b0) begin
         failures++; $display("FAIL mid_reset out_valid=%b y=%h cnt=%h in_ready=%b want 0 00 0000 0",
                              out_valid, y, cnt, in_ready);
      end
      rst_n = 1'b1;
      out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         failures++; $display("FAIL mid_ready in_ready=%b want 1", in_ready);
      end
      for (int i = 0; i < 5; i++) begin
         step(acc, dlv, yv, fv);
         if (dlv) ndlv++;
      end
      checks++;
      if (ndlv != 0) begin
         failures++; $display("FAIL mid_ghost deliveries=%0d want 0", ndlv);
      end
   endtask

   task automatic test_random();
      bit acc, dlv;
      logic [7:0] yv;
      logic [2:0] fv;
      logic [10:0] q [$];
      logic [10:0] e;
      int ndlv;
      ndlv = 0;
      for (int i = 0; i < 1100; i++) begin
         in_valid  = (i < 1000) ? 1'($urandom) : 1'b0;
         out_ready = (i < 1000) ? ($urandom_range(0, 3) != 0) : 1'b1;
         a = 8'($urandom); b = 8'($urandom); op = 3'($urandom);
         step(acc, dlv, yv, fv);
         if (acc) q.push_back(ref_res(a, b, op));
         if (dlv) begin
            ndlv++;
            checks++;
            if (q.size() == 0) begin
               failures++; $display("FAIL rand_extra y=%h with empty model queue", yv);
            end else begin
               e = q.pop_front();
               if (yv !== e[7:0]) begin
                  failures++; $display("FAIL rand_y n=%0d y=%h want %h", ndlv, yv, e[7:0]);
               end
`ifdef SEL_MUX8_PIPE_FLAGS_EN
               else if (fv !== e[10:8]) begin
                  failures++; $display("FAIL rand_flags n=%0d flags=%b want %b", ndlv, fv, e[10:8]);
               end
`endif
            end
         end
      end
      checks++;
      if (q.size() != 0) begin
         failures++; $display("FAIL rand_lost remaining=%0d want 0", q.size());
      end
      checks++;
      if (cnt !== 16'(ndlv)) begin
         failures++; $display("FAIL rand_cnt cnt=%0d want %0d", cnt, ndlv);
      end
   endtask

   task automatic test_cnt_wrap();
      bit acc, dlv;
      logic [7:0] yv;
      logic [2:0] fv;
      int ndlv;
      ndlv = 0;
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      in_valid = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 65600 && ndlv < 65536; i++) begin
         a = 8'($urandom); b = 8'($urandom); op = 3'($urandom);
         step(acc, dlv, yv, fv);
         if (dlv) begin
            ndlv++;
            if (ndlv == 65535) begin
               checks++;
               if (cnt !== 16'hFFFF) begin
                  failures++; $display("FAIL cnt_top cnt=%h want ffff", cnt);
               end
            end
         end
      end
      in_valid = 1'b0;
      checks++;
      if (ndlv != 65536) begin
         failures++; $display("FAIL cnt_budget deliveries=%0d want 65536", ndlv);
      end
      checks++;
      if (cnt !== 16'h0000) begin
         failures++; $display("FAIL cnt_wrap cnt=%h want 0000", cnt);
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_ops_n9();
      test_wrap();
      test_backpressure();
      test_reset_midflight();
      test_random();
      test_cnt_wrap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
